pkt_switch_4port: RTL and testbench

//  4-input/4-output packet switch with one 8-entry input FIFO per port and per-output round-robin arbiters.

---
 rtl/pkt_switch_4port.sv | 134 +++++++++++++
 tb/tb_pkt_switch_4port.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_switch_4port.sv
`default_nettype none
// ============================================================================
// Module   : pkt_switch_4port
// Purpose  : 4x4 packet switch, 8-deep input FIFOs, per-output round-robin
//            arbitration with multicast copy-out from each FIFO head.
// Revision : 1.0  initial release
// ============================================================================
module pkt_switch_4port #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             valid_in,
  input  logic [3:0][1:0]        source_in,
  input  logic [3:0][3:0]        target_in,
  input  logic [3:0][DATA_W-1:0] data_in,
  output logic [3:0]             valid_out,
  output logic [3:0][1:0]        source_out,
  output logic [3:0][3:0]        target_out,
  output logic [3:0][DATA_W-1:0] data_out,
  output logic [3:0]             fifo_full,
  output logic [3:0]             fifo_empty,
  output logic [3:0][CNT_W-1:0]  fifo_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ENT_W = DATA_W + 6;

  // Entry layout: {source[1:0], target[3:0], data}
  logic [ENT_W-1:0] mem     [4][FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr  [4];
  logic [AW-1:0]    rd_ptr  [4];
  logic [CNT_W-1:0] count   [4];
  logic [3:0]       served  [4];
  logic [1:0]       rr_ptr  [4];

  logic [ENT_W-1:0] head    [4];
  logic [3:0]       head_tgt[4];
  logic [3:0]       pending [4];
  logic [3:0]       gnt_in  [4];
  logic [1:0]       gnt_idx [4];
  logic [3:0]       gnt_valid;
  logic [3:0]       push;
  logic [3:0]       pop;
  logic [1:0]       cand;

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      fifo_count[p] = count[p];
      fifo_empty[p] = (count[p] == '0);
      fifo_full[p]  = (count[p] == CNT_W'(FIFO_DEPTH));
      head[p]       = mem[p][rd_ptr[p]];
      head_tgt[p]   = head[p][DATA_W +: 4];
      pending[p]    = fifo_empty[p] ? 4'b0 : (head_tgt[p] & ~served[p]);
      push[p]       = valid_in[p] && !fifo_full[p] && (target_in[p] != 4'b0);
    end
  end

  // Per-output round-robin search beginning at rr_ptr
  always_comb begin
    gnt_valid = '0;
    cand      = '0;
    for (int o = 0; o < 4; o++) gnt_idx[o] = '0;
    for (int p = 0; p < 4; p++) gnt_in[p] = '0;
    for (int o = 0; o < 4; o++) begin
      for (int k = 0; k < 4; k++) begin
        cand = rr_ptr[o] + 2'(k);
        if (!gnt_valid[o] && pending[cand][o]) begin
          gnt_valid[o]    = 1'b1;
          gnt_idx[o]      = cand;
          gnt_in[cand][o] = 1'b1;
        end
      end
    end
  end

  // A head retires on the edge its last outstanding copy is granted
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      pop[p] = !fifo_empty[p] &&
               (((served[p] | gnt_in[p]) & head_tgt[p]) == head_tgt[p]);
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (push[p]) mem[p][wr_ptr[p]] <= {source_in[p], target_in[p], data_in[p]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 4; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        count[p]  <= '0;
        served[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
        served[p] <= pop[p] ? 4'b0 : (served[p] | gnt_in[p]);
        case ({push[p], pop[p]})
          2'b10:   count[p] <= count[p] + 1'b1;
          2'b01:   count[p] <= count[p] - 1'b1;
          default: count[p] <= count[p];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out  <= '0;
      source_out <= '0;
      target_out <= '0;
      data_out   <= '0;
      for (int o = 0; o < 4; o++) rr_ptr[o] <= '0;
    end else begin
      valid_out <= gnt_valid;
      for (int o = 0; o < 4; o++) begin
        if (gnt_valid[o]) begin
          rr_ptr[o] <= gnt_idx[o] + 2'd1;
          {source_out[o], target_out[o], data_out[o]} <= head[gnt_idx[o]];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pkt_switch_4port.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_switch_4port
// Purpose  : Self-checking bench for pkt_switch_4port with an input-queue
//            reference model and a decoupled egress monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_pkt_switch_4port;

  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       valid_in;
  logic [3:0][1:0]  source_in;
  logic [3:0][3:0]  target_in;
  logic [3:0][7:0]  data_in;
  logic [3:0]       valid_out;
  logic [3:0][1:0]  source_out;
  logic [3:0][3:0]  target_out;
  logic [3:0][7:0]  data_out;
  logic [3:0]       fifo_full;
  logic [3:0]       fifo_empty;
  logic [3:0][3:0]  fifo_count;

  pkt_switch_4port #(.DATA_W(8), .FIFO_DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .source_in(source_in), .target_in(target_in), .data_in(data_in),
    .valid_out(valid_out), .source_out(source_out), .target_out(target_out), .data_out(data_out),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Reference: one queue of accepted packets per input; rem = copies still owed
  typedef struct {
    logic [3:0] rem;
    logic [3:0] tgt;
    logic [7:0] data;
  } pkt_t;
  pkt_t mq [4][$];

  int total = 0;
  int bad = 0;
  int delivered = 0;
  int drops = 0;
  int exp_copies = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_fill();
    int s = 0;
    for (int p = 0; p < 4; p++) s += mq[p].size();
    return s;
  endfunction

  task automatic apply(input logic [3:0] v, input logic [3:0][3:0] tgt, input logic [3:0][7:0] d);
    pkt_t pk;
    for (int p = 0; p < 4; p++) begin
      if (v[p] && mq[p].size() >= DEPTH) drops++;
      else if (v[p] && tgt[p] != 4'b0) begin
        pk.rem = tgt[p]; pk.tgt = tgt[p]; pk.data = d[p];
        mq[p].push_back(pk);
        exp_copies += $countones(tgt[p]);
      end
    end
    valid_in = v; target_in = tgt; data_in = d;
  endtask

  task automatic drain(input string name);
    int n = 0;
    @(negedge clk);
    apply(4'b0, '0, '0);
    while ((fifo_empty != 4'hF || model_fill() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_fifo_empty"}, 32'(fifo_empty), 32'hF);
    check({name, "_model_empty"}, 32'(model_fill()), 0);
    check({name, "_conservation"}, 32'(delivered), 32'(exp_copies));
  endtask

  task automatic clear_stats();
    delivered = 0; drops = 0; exp_copies = 0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    valid_in = '0;
    for (int p = 0; p < 4; p++) mq[p].delete();
    #1;
    check("reset_count", 32'(fifo_count), 0);
    check("reset_valid_out", 32'(valid_out), 0);
    check("reset_empty", 32'(fifo_empty), 32'hF);
    check("reset_full", 32'(fifo_full), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
  endtask

  // Egress monitor: every presented copy must match the head of its source queue
  always begin
    pkt_t h;
    int p;
    @(posedge clk);
    #1;
    if (!rst) begin
      for (int o = 0; o < 4; o++) begin
        if (valid_out[o]) begin
          p = int'(source_out[o]);
          delivered++;
          if (mq[p].size() == 0 || !mq[p][0].rem[o]) begin
            total++;
            bad++;
            $display("FAIL unexpected_egress: out=%0d src=%0d data=%0h, no such copy owed", o, p, data_out[o]);
          end else begin
            h = mq[p].pop_front();
            check("egress_data", 32'(data_out[o]), 32'(h.data));
            check("egress_target", 32'(target_out[o]), 32'(h.tgt));
            h.rem[o] = 1'b0;
            if (h.rem != 4'b0) mq[p].push_front(h);
          end
        end
      end
      for (int q = 0; q < 4; q++) begin
        check("fifo_count", 32'(fifo_count[q]), 32'(mq[q].size()));
        check("fifo_full", 32'(fifo_full[q]), 32'(mq[q].size() == DEPTH));
        check("fifo_empty", 32'(fifo_empty[q]), 32'(mq[q].size() == 0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][3:0] t;
    logic [3:0][7:0] d;
    logic [3:0]      v;
    int              left [4];
    int              n;

    valid_in = '0; target_in = '0; data_in = '0;
    for (int p = 0; p < 4; p++) source_in[p] = 2'(p);

    #1;
    check("por_count", 32'(fifo_count), 0);
    check("por_empty", 32'(fifo_empty), 32'hF);
    check("por_full", 32'(fifo_full), 0);
    check("por_valid_out", 32'(valid_out), 0);
    check("por_data_out", 32'(data_out), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Unicast port0 -> output 2
    @(negedge clk);
    t = '0; d = '0; t[0] = 4'b0100; d[0] = 8'hA5;
    apply(4'b0001, t, d);
    @(posedge clk); #1;
    check("uni_not_early", 32'(valid_out), 0);
    @(negedge clk);
    apply(4'b0, '0, '0);
    @(posedge clk); #1;
    check("uni_valid", 32'(valid_out), 32'b0100);
    check("uni_data", 32'(data_out[2]), 32'hA5);
    check("uni_src", 32'(source_out[2]), 0);

    // Multicast port1 -> outputs 0,1,3
    @(negedge clk);
    t = '0; d = '0; t[1] = 4'b1011; d[1] = 8'h3C;
    apply(4'b0010, t, d);
    @(negedge clk);
    apply(4'b0, '0, '0);
    @(posedge clk); #1;
    check("mc_valid", 32'(valid_out), 32'b1011);
    check("mc_data0", 32'(data_out[0]), 32'h3C);
    check("mc_data1", 32'(data_out[1]), 32'h3C);
    check("mc_data3", 32'(data_out[3]), 32'h3C);
    check("mc_fifo1_empty", 32'(fifo_empty[1]), 1);
    @(posedge clk); #1;
    check("mc_once", 32'(valid_out), 0);
    check("mc_hold", 32'(data_out[0]), 32'h3C);

    // Contention on output 0 straight after reset
    do_reset();
    @(negedge clk);
    t = '0;
    for (int p = 0; p < 4; p++) begin t[p] = 4'b0001; d[p] = 8'(8'h10 + p); end
    apply(4'hF, t, d);
    @(negedge clk);
    apply(4'b0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("rr_valid", 32'(valid_out[0]), 1);
      check("rr_order_src", 32'(source_out[0]), 32'(k));
    end
    drain("contention");

    // Overflow: all inputs hammer output 0 for 20 cycles
    clear_stats();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin t[p] = 4'b0001; d[p] = 8'($urandom); end
      apply(4'hF, t, d);
    end
    drain("overflow");
    check("overflow_delivered", 32'(delivered), 32'(80 - drops));
    check("overflow_drops_seen", 32'(drops > 0), 1);

    // Reset with FIFOs partly filled
    clear_stats();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin t[p] = 4'b0001 << (p ^ 1); d[p] = 8'($urandom); end
      apply(4'hF, t, d);
    end
    do_reset();
    for (int c = 0; c < 10; c++) @(negedge clk);
    check("post_reset_silent", 32'(delivered), 0);
    check("post_reset_empty", 32'(fifo_empty), 32'hF);

    // Random traffic, 20 packets per port
    clear_stats();
    for (int p = 0; p < 4; p++) left[p] = 20;
    n = 0;
    while ((left[0] + left[1] + left[2] + left[3]) > 0 && n < 1000) begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        v[p] = (left[p] > 0) && ($urandom_range(0, 1) == 1);
        t[p] = 4'($urandom_range(0, 15));
        d[p] = 8'($urandom);
        if (v[p]) left[p]--;
      end
      apply(v, t, d);
      n++;
    end
    check("random_all_sent", 32'(left[0] + left[1] + left[2] + left[3]), 0);
    drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
